// File: rtl/csa_result_stage.sv
// ---------------------------------------------------------------------------
// csa_result_stage
//
// First register boundary after the 8-bit carry-select adder. Each accepted
// adder result (sum plus carry-out, with the operands that produced it) gets
// its condition flags {C,V,N,Z}. The result is held in a 2-entry skid buffer
// and presented to the next ALU stage on a valid/ready interface.
//
// Optional feature macro: RESULT_STATS_EN
//   When defined, two saturating counters (carry_count, ovf_count) and their
//   synchronous clear input (stats_clear) are added. Buffer behaviour is the
//   same in both builds.
//
// Parameters
//   WIDTH      operand / sum width
//   CNT_WIDTH  statistics counter width (RESULT_STATS_EN only)
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   in_valid     in   adder result present on in_* this cycle
//   in_ready     out  stage can accept a result this cycle
//   in_a, in_b   in   operands as applied to the adder
//   in_sum       in   adder sum
//   in_cout      in   adder carry-out
//   out_valid    out  head entry valid
//   out_ready    in   consumer accepts head entry
//   out_sum      out  head entry sum
//   out_flags    out  head entry flags {C,V,N,Z}
//   stats_clear  in   (RESULT_STATS_EN) clear both counters
//   carry_count  out  (RESULT_STATS_EN) accepted results with C=1
//   ovf_count    out  (RESULT_STATS_EN) accepted results with V=1
//   dbg_state    out  buffer state: 0 EMPTY, 1 ONE, 2 TWO
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Push = in_valid && in_ready, pop = out_valid && out_ready.
// A producer must hold in_* stable while in_valid is high and in_ready low.
// in_ready depends only on registered state (and reset), never on out_ready.
// ---------------------------------------------------------------------------
module csa_result_stage #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [WIDTH-1:0]     in_sum,
  input  logic                 in_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_sum,
  output logic [3:0]           out_flags,
`ifdef RESULT_STATS_EN
  input  logic                 stats_clear,
  output logic [CNT_WIDTH-1:0] carry_count,
  output logic [CNT_WIDTH-1:0] ovf_count,
`endif
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic             w_push;
  logic             w_pop;
  logic [3:0]       w_flags;

  logic [WIDTH-1:0] r_head_sum;
  logic [3:0]       r_head_flags;
  logic [WIDTH-1:0] r_tail_sum;
  logic [3:0]       r_tail_flags;

  // Only the operand MSBs feed the overflow flag; the low bits are
  // intentionally not used.
  logic w_unused_operand_bits;
  assign w_unused_operand_bits = ^{in_a[WIDTH-2:0], in_b[WIDTH-2:0]};

  // V only looks at MSBs, so it is correct whatever carry-in the adder used.
  assign w_flags[3] = in_cout;
  assign w_flags[2] = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                      (in_sum[WIDTH-1] != in_a[WIDTH-1]);
  assign w_flags[1] = in_sum[WIDTH-1];
  assign w_flags[0] = (in_sum == '0);

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) w_next_state = ST_ONE;
      end
      ST_ONE: begin
        if (w_push && !w_pop)      w_next_state = ST_TWO;
        else if (w_pop && !w_push) w_next_state = ST_EMPTY;
      end
      ST_TWO: begin
        if (w_pop) w_next_state = ST_ONE;
      end
      default: w_next_state = ST_EMPTY;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // in_ready is forced low during reset so an offer in the reset cycle is
  // never acknowledged.
  always_comb begin
    in_ready  = (r_state != ST_TWO) && !reset;
    out_valid = (r_state != ST_EMPTY);
    dbg_state = r_state;
  end

  // ---------------- Entry storage ----------------
  // The head register always drives out_*. In EMPTY it keeps its last
  // value. A push in ONE with a simultaneous pop replaces the head directly;
  // without a pop it lands in the tail. Leaving TWO moves tail to head.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head_sum   <= '0;
      r_head_flags <= 4'b0000;
      r_tail_sum   <= '0;
      r_tail_flags <= 4'b0000;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            r_head_sum   <= in_sum;
            r_head_flags <= w_flags;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            r_head_sum   <= in_sum;
            r_head_flags <= w_flags;
          end else if (w_push) begin
            r_tail_sum   <= in_sum;
            r_tail_flags <= w_flags;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            r_head_sum   <= r_tail_sum;
            r_head_flags <= r_tail_flags;
          end
        end
        default: begin
          r_head_sum   <= r_head_sum;
          r_head_flags <= r_head_flags;
        end
      endcase
    end
  end

  assign out_sum   = r_head_sum;
  assign out_flags = r_head_flags;

`ifdef RESULT_STATS_EN
  // ---------------- Statistics counters ----------------
  // Saturate at all-ones; clear wins over a same-cycle increment.
  logic [CNT_WIDTH-1:0] r_carry_count;
  logic [CNT_WIDTH-1:0] r_ovf_count;

  always_ff @(posedge clock) begin
    if (reset || stats_clear) begin
      r_carry_count <= '0;
      r_ovf_count   <= '0;
    end else begin
      if (w_push && w_flags[3] && (r_carry_count != '1)) begin
        r_carry_count <= r_carry_count + CNT_WIDTH'(1);
      end
      if (w_push && w_flags[2] && (r_ovf_count != '1)) begin
        r_ovf_count <= r_ovf_count + CNT_WIDTH'(1);
      end
    end
  end

  assign carry_count = r_carry_count;
  assign ovf_count   = r_ovf_count;
`endif

endmodule

// File: tb/tb_csa_result_stage.sv
// ---------------------------------------------------------------------------
// tb_csa_result_stage
//
// Directed self-checking bench for csa_result_stage. Inputs are driven #1
// after the rising edge and outputs are sampled at the same point, so all
// checks see settled post-edge values. Builds with or without
// RESULT_STATS_EN.
// ---------------------------------------------------------------------------
module tb_csa_result_stage;

  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 16;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a = '0;
  logic [WIDTH-1:0]     in_b = '0;
  logic [WIDTH-1:0]     in_sum = '0;
  logic                 in_cout = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [WIDTH-1:0]     out_sum;
  logic [3:0]           out_flags;
  logic [1:0]           dbg_state;
`ifdef RESULT_STATS_EN
  logic                 stats_clear = 1'b0;
  logic [CNT_WIDTH-1:0] carry_count;
  logic [CNT_WIDTH-1:0] ovf_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  csa_result_stage #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sum     (in_sum),
    .in_cout    (in_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_flags  (out_flags),
`ifdef RESULT_STATS_EN
    .stats_clear(stats_clear),
    .carry_count(carry_count),
    .ovf_count  (ovf_count),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] s, input logic c);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sum   = s;
    in_cout  = c;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    offer(8'h12, 8'h43, 8'h55, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL reset_out_valid cyc%0d got %b want 0", i, out_valid);
      end
      n_vec++;
      if (out_sum !== 8'h00) begin
        n_err++; $display("FAIL reset_out_sum cyc%0d got %h want 00", i, out_sum);
      end
      n_vec++;
      if (out_flags !== 4'b0000) begin
        n_err++; $display("FAIL reset_out_flags cyc%0d got %b want 0000", i, out_flags);
      end
      n_vec++;
      if (in_ready !== 1'b0) begin
        n_err++; $display("FAIL reset_in_ready cyc%0d got %b want 0", i, in_ready);
      end
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL post_reset_in_ready got %b want 1", in_ready);
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL post_reset_out_valid got %b want 0", out_valid);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_offer_dropped got valid %b want 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    offer(8'h7F, 8'h01, 8'h80, 1'b0);
    step();
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL ovf_valid got %b want 1", out_valid);
    end
    n_vec++;
    if (out_sum !== 8'h80) begin
      n_err++; $display("FAIL ovf_sum got %h want 80", out_sum);
    end
    n_vec++;
    if (out_flags !== 4'b0110) begin
      n_err++; $display("FAIL ovf_flags got %b want 0110", out_flags);
    end
  endtask

  task automatic test_carry_zero();
    out_ready = 1'b1;
    offer(8'hFF, 8'h01, 8'h00, 1'b1);
    step();
    n_vec++;
    if (out_sum !== 8'h00 || out_flags !== 4'b1001) begin
      n_err++; $display("FAIL carry_zero got sum %h flags %b want 00 1001", out_sum, out_flags);
    end
    offer(8'h80, 8'h80, 8'h00, 1'b1);
    step();
    n_vec++;
    if (out_sum !== 8'h00 || out_flags !== 4'b1101) begin
      n_err++; $display("FAIL carry_ovf_zero got sum %h flags %b want 00 1101", out_sum, out_flags);
    end
    in_valid = 1'b0;
    step();
    n_vec++;
    if (out_valid !== 1'b0 || dbg_state !== 2'd0) begin
      n_err++; $display("FAIL drain_empty got valid %b state %0d want 0 0", out_valid, dbg_state);
    end
    n_vec++;
    if (out_sum !== 8'h00 || out_flags !== 4'b1101) begin
      n_err++; $display("FAIL empty_hold got sum %h flags %b want 00 1101", out_sum, out_flags);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    offer(8'h00, 8'h01, 8'h01, 1'b0);
    step();
    offer(8'h00, 8'h02, 8'h02, 1'b0);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_ready_one got %b want 1", in_ready);
    end
    step();
    offer(8'h00, 8'h03, 8'h03, 1'b0);
    n_vec++;
    if (in_ready !== 1'b0 || dbg_state !== 2'd2) begin
      n_err++; $display("FAIL bp_full got ready %b state %0d want 0 2", in_ready, dbg_state);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b1 || out_sum !== 8'h01 || out_flags !== 4'b0000 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_hold got valid %b sum %h flags %b ready %b want 1 01 0000 0",
                        out_valid, out_sum, out_flags, in_ready);
    end
    out_ready = 1'b1;
    step();
    n_vec++;
    if (out_valid !== 1'b1 || out_sum !== 8'h02 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_second got valid %b sum %h ready %b want 1 02 1",
                        out_valid, out_sum, in_ready);
    end
    step();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_sum !== 8'h03) begin
      n_err++; $display("FAIL bp_third got valid %b sum %h want 1 03", out_valid, out_sum);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_drained got valid %b want 0", out_valid);
    end
  endtask

  task automatic test_streaming();
    logic [7:0] s;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s = 8'(i);
      offer(8'h00, s, s, 1'b0);
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++; $display("FAIL stream_ready i%0d got %b want 1", i, in_ready);
      end
      step();
      n_vec++;
      if (out_valid !== 1'b1 || out_sum !== s ||
          out_flags !== ((i == 0) ? 4'b0001 : 4'b0000)) begin
        n_err++; $display("FAIL stream_out i%0d got valid %b sum %h flags %b want 1 %h",
                          i, out_valid, out_sum, out_flags, s);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

`ifdef RESULT_STATS_EN
  task automatic test_stats();
    out_ready   = 1'b1;
    in_valid    = 1'b0;
    stats_clear = 1'b1;
    step();
    stats_clear = 1'b0;
    n_vec++;
    if (carry_count !== 16'd0 || ovf_count !== 16'd0) begin
      n_err++; $display("FAIL stats_clear_idle got %0d %0d want 0 0", carry_count, ovf_count);
    end
    for (int i = 0; i < 300; i++) begin
      if (i % 60 == 7) offer(8'h80, 8'h80, 8'h00, 1'b1);
      else             offer(8'hFF, 8'h01, 8'h00, 1'b1);
      step();
    end
    in_valid = 1'b0;
    step();
    n_vec++;
    if (carry_count !== 16'd300) begin
      n_err++; $display("FAIL stats_carry got %0d want 300", carry_count);
    end
    n_vec++;
    if (ovf_count !== 16'd5) begin
      n_err++; $display("FAIL stats_ovf got %0d want 5", ovf_count);
    end
    offer(8'h80, 8'h80, 8'h00, 1'b1);
    stats_clear = 1'b1;
    step();
    stats_clear = 1'b0;
    in_valid    = 1'b0;
    n_vec++;
    if (carry_count !== 16'd0 || ovf_count !== 16'd0) begin
      n_err++; $display("FAIL stats_clear_prio got %0d %0d want 0 0", carry_count, ovf_count);
    end
    step();
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_overflow();
    test_carry_zero();
    test_backpressure();
    test_streaming();
`ifdef RESULT_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
